// File: rtl/i2c_bus_condition_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_condition_gen_if
//  Description : Command handshake and open-drain line bundle for the I2C
//                bus-condition engine. The master side is the byte/bit
//                sequencer together with the pad model; the slave side is the
//                engine itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_bus_condition_gen_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       done;
    logic       timeout;
    logic       bus_error;
    logic       bus_owned;
    logic       sda_oe;
    logic       scl_oe;
    logic       sda_in;
    logic       scl_in;

    modport master (
        output cmd_valid, cmd, sda_in, scl_in,
        input  cmd_ready, done, timeout, bus_error, bus_owned, sda_oe, scl_oe
    );

    modport slave (
        input  cmd_valid, cmd, sda_in, scl_in,
        output cmd_ready, done, timeout, bus_error, bus_owned, sda_oe, scl_oe
    );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_condition_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_condition_gen
//  Description : Generates I2C START, repeated START and STOP on open-drain
//                SDA/SCL (oe=1 pulls low) with quarter-period timing, SCL
//                clock-stretch detection and stretch timeout.
//                Optional bus checking is enabled by defining the macro
//                I2C_BUS_COND_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_condition_gen #(
    parameter int CLK_DIV         = 125,
    parameter int STRETCH_TIMEOUT = 50000,
    parameter int TIMER_W         = 16
) (
    input wire                       clk,
    input wire                       reset,
    i2c_bus_condition_gen_if.slave   bus
);

    localparam logic [1:0]         c_CMD_START  = 2'b00;
    localparam logic [1:0]         c_CMD_RSTART = 2'b01;
    localparam logic [1:0]         c_CMD_STOP   = 2'b10;
    localparam logic [TIMER_W-1:0] c_PHASE_LAST = TIMER_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] c_TMO_LAST   = TIMER_W'(STRETCH_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_ONE        = TIMER_W'(1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        RS_SDA_REL = 4'd1,
        RS_SCL_REL = 4'd2,
        ST_SDA_LO  = 4'd3,
        ST_SCL_LO  = 4'd4,
        SP_SDA_LO  = 4'd5,
        SP_SCL_REL = 4'd6,
        SP_SDA_REL = 4'd7,
        FINISH     = 4'd8
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [TIMER_W-1:0] r_phase_cnt, w_phase_nxt;
    logic [TIMER_W-1:0] r_tmo_cnt, w_tmo_nxt;
    logic               r_scl_seen, w_seen_nxt;
    logic               r_sda_oe, w_sda_oe_nxt;
    logic               r_scl_oe, w_scl_oe_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic               r_bus_error, w_bus_error_nxt;
    logic               r_bus_owned, w_bus_owned_nxt;

    logic               r_sda_meta, r_sda_sync;
    logic               r_scl_meta, r_scl_sync;

    logic               w_phase_last;
    logic               w_lines_idle;   // both lines high before taking the bus
    logic               w_sda_lost;     // SDA failed to rise at the end of STOP

`ifdef I2C_BUS_COND_CHECK_EN
    assign w_lines_idle = r_sda_sync & r_scl_sync;
    assign w_sda_lost   = ~r_sda_sync;
`else
    logic               w_unused_sda;
    assign w_lines_idle = 1'b1;
    assign w_sda_lost   = 1'b0;
    assign w_unused_sda = r_sda_sync;
`endif

    assign w_phase_last  = (r_phase_cnt == c_PHASE_LAST);

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.done      = (r_state == FINISH);
    assign bus.sda_oe    = r_sda_oe;
    assign bus.scl_oe    = r_scl_oe;
    assign bus.timeout   = r_timeout;
    assign bus.bus_error = r_bus_error;
    assign bus.bus_owned = r_bus_owned;

    // Two-flop synchronisers on the raw line levels; idle bus reads high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
        end else begin
            r_sda_meta <= bus.sda_in;
            r_sda_sync <= r_sda_meta;
            r_scl_meta <= bus.scl_in;
            r_scl_sync <= r_scl_meta;
        end
    end

    // State, counters and registered line/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_scl_seen  <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_timeout   <= 1'b0;
            r_bus_error <= 1'b0;
            r_bus_owned <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_cnt <= w_phase_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_scl_seen  <= w_seen_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_scl_oe    <= w_scl_oe_nxt;
            r_timeout   <= w_timeout_nxt;
            r_bus_error <= w_bus_error_nxt;
            r_bus_owned <= w_bus_owned_nxt;
        end
    end

    // Next-state and next-output decode; every line change is registered.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase_cnt;
        w_tmo_nxt       = r_tmo_cnt;
        w_seen_nxt      = r_scl_seen;
        w_sda_oe_nxt    = r_sda_oe;
        w_scl_oe_nxt    = r_scl_oe;
        w_timeout_nxt   = r_timeout;
        w_bus_error_nxt = r_bus_error;
        w_bus_owned_nxt = r_bus_owned;

        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_timeout_nxt   = 1'b0;
                    w_bus_error_nxt = 1'b0;
                    w_phase_nxt     = '0;
                    case (bus.cmd)
                        c_CMD_START, c_CMD_RSTART: begin
                            if (bus.cmd == c_CMD_RSTART && r_bus_owned) begin
                                w_state_nxt  = RS_SDA_REL;
                                w_sda_oe_nxt = 1'b0;
                            end else if (!r_bus_owned && !w_lines_idle) begin
                                // Someone else holds the bus: refuse to drive it.
                                w_state_nxt     = FINISH;
                                w_bus_error_nxt = 1'b1;
                                w_sda_oe_nxt    = 1'b0;
                                w_scl_oe_nxt    = 1'b0;
                                w_bus_owned_nxt = 1'b0;
                            end else begin
                                w_state_nxt  = ST_SDA_LO;
                                w_sda_oe_nxt = 1'b1;
                            end
                        end
                        c_CMD_STOP: begin
                            if (r_bus_owned) begin
                                w_state_nxt  = SP_SDA_LO;
                                w_sda_oe_nxt = 1'b1;
                            end else begin
                                w_state_nxt = FINISH;
                            end
                        end
                        default: begin
                            w_state_nxt     = FINISH;
                            w_bus_error_nxt = 1'b1;
                        end
                    endcase
                end
            end

            RS_SDA_REL, ST_SDA_LO, ST_SCL_LO, SP_SDA_LO, SP_SDA_REL: begin
                if (w_phase_last) begin
                    w_phase_nxt = '0;
                    w_tmo_nxt   = '0;
                    w_seen_nxt  = 1'b0;
                    case (r_state)
                        RS_SDA_REL: begin
                            w_state_nxt  = RS_SCL_REL;
                            w_scl_oe_nxt = 1'b0;
                        end
                        ST_SDA_LO: begin
                            w_state_nxt  = ST_SCL_LO;
                            w_scl_oe_nxt = 1'b1;
                        end
                        ST_SCL_LO: begin
                            w_state_nxt     = FINISH;
                            w_bus_owned_nxt = 1'b1;
                        end
                        SP_SDA_LO: begin
                            w_state_nxt  = SP_SCL_REL;
                            w_scl_oe_nxt = 1'b0;
                        end
                        default: begin
                            // End of STOP: SDA should now read high.
                            w_state_nxt     = FINISH;
                            w_bus_owned_nxt = 1'b0;
                            w_sda_oe_nxt    = 1'b0;
                            w_scl_oe_nxt    = 1'b0;
                            if (w_sda_lost) begin
                                w_bus_error_nxt = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    w_phase_nxt = r_phase_cnt + c_ONE;
                end
            end

            RS_SCL_REL, SP_SCL_REL: begin
                // Phase timing begins only once the slave lets SCL rise.
                if (r_scl_seen || r_scl_sync) begin
                    w_seen_nxt = 1'b1;
                    if (w_phase_last) begin
                        w_phase_nxt = '0;
                        if (r_state == RS_SCL_REL) begin
                            w_state_nxt  = ST_SDA_LO;
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = SP_SDA_REL;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end else begin
                        w_phase_nxt = r_phase_cnt + c_ONE;
                    end
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_state_nxt     = FINISH;
                    w_sda_oe_nxt    = 1'b0;
                    w_scl_oe_nxt    = 1'b0;
                    w_timeout_nxt   = 1'b1;
                    w_bus_owned_nxt = 1'b0;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + c_ONE;
                end
            end

            FINISH: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_condition_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_bus_condition_gen
//  Description : Directed bench for i2c_bus_condition_gen with CLK_DIV=4 and
//                STRETCH_TIMEOUT=20. Pull-ups are modelled as line = ~oe,
//                with optional slave SCL stretching and SDA forced low.
//                Expectations follow I2C_BUS_COND_CHECK_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_condition_gen;

    localparam int CLK_DIV         = 4;
    localparam int STRETCH_TIMEOUT = 20;
    localparam int TIMER_W         = 16;
    localparam int LIMIT           = 100;
    localparam int HOLD_FOREVER    = -1;

`ifdef I2C_BUS_COND_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [1:0] cmd;
        int         stretch;     // SCL low cycles after release; -1 = forever
        bit         force_sda;   // hold SDA low for the whole transaction
        int         exp_done;    // cycle of done relative to accept
        bit         exp_to;
        bit         exp_be;
        bit         exp_own;
        bit         exp_sda;     // sda_oe at done
        bit         exp_scl;     // scl_oe at done
        int         sda_first;   // first/last sda_oe change cycle, 0 = none
        int         sda_last;
        int         scl_first;
        int         scl_last;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic force_sda;
    int   stretch_left;
    int   n_checks;
    int   n_fail;

    i2c_bus_condition_gen_if bus();

    assign bus.sda_in = ~bus.sda_oe & ~force_sda;
    assign bus.scl_in = ~bus.scl_oe & (stretch_left == 0);

    i2c_bus_condition_gen #(
        .CLK_DIV        (CLK_DIV),
        .STRETCH_TIMEOUT(STRETCH_TIMEOUT),
        .TIMER_W        (TIMER_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one command at a negedge; it is accepted at the next posedge (cycle 0).
    task automatic issue(input logic [1:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   done_cyc, sf, sl, cf, cl;
        bit   ready_bad;
        logic prev_sda, prev_scl;
        int   to_d, be_d, own_d, sda_d, scl_d;
        force_sda    = v.force_sda;
        stretch_left = v.stretch;
        repeat (3) @(negedge clk);
        chk({tag, " ready_before"}, int'(bus.cmd_ready), 1);
        prev_sda = bus.sda_oe;
        prev_scl = bus.scl_oe;
        issue(v.cmd);
        done_cyc = -1; sf = 0; sl = 0; cf = 0; cl = 0; ready_bad = 1'b0;
        to_d = 0; be_d = 0; own_d = 0; sda_d = 0; scl_d = 0;
        for (int c = 1; c <= LIMIT && done_cyc < 0; c++) begin
            @(negedge clk);
            if (bus.sda_oe !== prev_sda) begin
                if (sf == 0) sf = c;
                sl = c;
                prev_sda = bus.sda_oe;
            end
            if (bus.scl_oe !== prev_scl) begin
                if (cf == 0) cf = c;
                cl = c;
                prev_scl = bus.scl_oe;
            end
            if (bus.cmd_ready !== 1'b0) ready_bad = 1'b1;
            if (bus.done === 1'b1) begin
                done_cyc = c;
                to_d  = int'(bus.timeout);
                be_d  = int'(bus.bus_error);
                own_d = int'(bus.bus_owned);
                sda_d = int'(bus.sda_oe);
                scl_d = int'(bus.scl_oe);
            end
            if (!bus.scl_oe && stretch_left > 0) stretch_left--;
        end
        chk({tag, " done_cycle"}, done_cyc, v.exp_done);
        chk({tag, " timeout"},    to_d,  int'(v.exp_to));
        chk({tag, " bus_error"},  be_d,  int'(v.exp_be));
        chk({tag, " bus_owned"},  own_d, int'(v.exp_own));
        chk({tag, " sda_oe"},     sda_d, int'(v.exp_sda));
        chk({tag, " scl_oe"},     scl_d, int'(v.exp_scl));
        chk({tag, " sda_first"},  sf, v.sda_first);
        chk({tag, " sda_last"},   sl, v.sda_last);
        chk({tag, " scl_first"},  cf, v.scl_first);
        chk({tag, " scl_last"},   cl, v.scl_last);
        chk({tag, " ready_low_while_busy"}, int'(ready_bad), 0);
        @(negedge clk);
        chk({tag, " ready_after_done"}, int'(bus.cmd_ready), 1);
        chk({tag, " done_one_cycle"},   int'(bus.done), 0);
        chk({tag, " timeout_held"},     int'(bus.timeout), int'(v.exp_to));
        force_sda    = 1'b0;
        stretch_left = 0;
    endtask

    vec_t vecs[14];

    initial begin
        vec_t v_start;
        int   dc;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        force_sda     = 1'b0;
        stretch_left  = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;

        //          cmd    str  fsda done to  be   own sda scl  sf  sl  cf  cl
        vecs[0]  = '{2'b00, 0,  0,   9, 0, 0,   1,  1,  1,   1,  1,  5,  5};
        vecs[1]  = '{2'b10, 10, 0,  24, 0, 0,   0,  0,  0,  20, 20,  5,  5};
        vecs[2]  = '{2'b00, 0,  0,   9, 0, 0,   1,  1,  1,   1,  1,  5,  5};
        vecs[3]  = '{2'b01, 0,  0,  19, 0, 0,   1,  1,  1,   1, 11,  5, 15};
        vecs[4]  = '{2'b10, HOLD_FOREVER, 0, 25, 1, 0, 0, 0, 0, 25, 25, 5, 5};
        vecs[5]  = '{2'b10, 0,  0,   1, 0, 0,   0,  0,  0,   0,  0,  0,  0};
        vecs[6]  = '{2'b01, 0,  0,   9, 0, 0,   1,  1,  1,   1,  1,  5,  5};
        vecs[7]  = '{2'b10, 0,  1,  15, 0, CHK, 0,  0,  0,  11, 11,  5,  5};
        vecs[8]  = '{2'b11, 0,  0,   1, 0, 1,   0,  0,  0,   0,  0,  0,  0};
        vecs[9]  = '{2'b00, 0,  0,   9, 0, 0,   1,  1,  1,   1,  1,  5,  5};
        vecs[10] = '{2'b11, 0,  0,   1, 0, 1,   1,  1,  1,   0,  0,  0,  0};
        vecs[11] = '{2'b10, 0,  0,  15, 0, 0,   0,  0,  0,  11, 11,  5,  5};
`ifdef I2C_BUS_COND_CHECK_EN
        vecs[12] = '{2'b00, 0,  1,   1, 0, 1,   0,  0,  0,   0,  0,  0,  0};
        vecs[13] = '{2'b10, 0,  0,   1, 0, 0,   0,  0,  0,   0,  0,  0,  0};
`else
        vecs[12] = '{2'b00, 0,  1,   9, 0, 0,   1,  1,  1,   1,  1,  5,  5};
        vecs[13] = '{2'b10, 0,  0,  15, 0, 0,   0,  0,  0,  11, 11,  5,  5};
`endif

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst sda_oe",    int'(bus.sda_oe), 0);
        chk("rst scl_oe",    int'(bus.scl_oe), 0);
        chk("rst done",      int'(bus.done), 0);
        chk("rst timeout",   int'(bus.timeout), 0);
        chk("rst bus_error", int'(bus.bus_error), 0);
        chk("rst bus_owned", int'(bus.bus_owned), 0);
        chk("rst cmd_ready", int'(bus.cmd_ready), 1);
        reset = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("v%0d", i));

        // cmd_valid while busy is ignored and not queued.
        repeat (3) @(negedge clk);
        issue(2'b00);
        dc = -1;
        for (int c = 1; c <= LIMIT && dc < 0; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus.cmd_valid = 1'b1;
                bus.cmd       = 2'b11;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (bus.done === 1'b1) begin
                dc = c;
                chk("busy_ignore bus_error", int'(bus.bus_error), 0);
            end
        end
        chk("busy_ignore done_cycle", dc, 9);
        repeat (2) begin
            @(negedge clk);
            chk("busy_ignore no_requeue_done", int'(bus.done), 0);
            chk("busy_ignore ready", int'(bus.cmd_ready), 1);
        end

        // Asynchronous reset in the middle of a STOP.
        issue(2'b10);
        repeat (6) @(negedge clk);
        chk("mid_stop sda_oe_before", int'(bus.sda_oe), 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_stop rst sda_oe",    int'(bus.sda_oe), 0);
        chk("mid_stop rst scl_oe",    int'(bus.scl_oe), 0);
        chk("mid_stop rst bus_owned", int'(bus.bus_owned), 0);
        chk("mid_stop rst cmd_ready", int'(bus.cmd_ready), 1);
        chk("mid_stop rst done",      int'(bus.done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_stop ready_after_release", int'(bus.cmd_ready), 1);
        v_start = '{2'b00, 0, 0, 9, 0, 0, 1, 1, 1, 1, 1, 5, 5};
        run_txn(v_start, "post_reset_start");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
